// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Holds the responder FSM states and address decode helpers.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    LOAD
  } dmem_state_e;

  localparam int DW_BYTES = 8;

  function automatic logic [63:0] dw_index(
    input logic [63:0] addr
  );
    return addr >> 3;
  endfunction

  // In range only if the whole doubleword fits; computed on
  // 65 bits so addresses near 2^64 cannot wrap back in range.
  function automatic logic addr_ok(
    input logic [63:0] addr,
    input logic [63:0] depth
  );
    logic [64:0] last_b;
    last_b = {1'b0, addr} + 65'd7;
    return (addr[2:0] == 3'b000) &&
           (last_b < {1'b0, depth});
  endfunction

endpackage

// File: rtl/dmem_init_loader.sv
// Preload sequencer: doubleword index, pending-start flag, write mux.
// Ports: state_i, init_en_i, init_data_i in; start_o, last_o, wsel_o, idx_o, wdata_o out.
module dmem_init_loader
  import riscv_mem_pkg::*;
#(
  parameter int NUM_INIT = 8,
  parameter int IW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  dmem_state_e              state_i,
  input  logic                     init_en_i,
  input  logic [64*NUM_INIT-1:0]   init_data_i,
  output logic                     start_o,
  output logic                     last_o,
  output logic                     wsel_o,
  output logic [IW-1:0]            idx_o,
  output logic [63:0]              wdata_o
);

  logic [IW-1:0] idx_q, idx_d;
  logic          pend_q, pend_d;

  always_comb begin
    last_o  = (idx_q == IW'(NUM_INIT - 1));
    wsel_o  = (state_i == LOAD);
    idx_o   = idx_q;
    wdata_o = init_data_i[64*int'(idx_q) +: 64];
    // a start request seen in RESP itself counts as pending
    start_o = pend_q | init_en_i;
    idx_d   = idx_q;
    pend_d  = pend_q;
    unique case (state_i)
      BUSY: begin
        if (init_en_i) pend_d = 1'b1;
      end
      RESP: begin
        pend_d = 1'b0;
      end
      LOAD: begin
        idx_d = last_o ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request side and preload.
// Ports: req_* in, req_ready/rsp_*/stall_req/init_busy out, init_en/init_data in.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2,
  parameter int NUM_INIT    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [63:0]            req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [63:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   stall_req,
  input  logic                   init_en,
  input  logic [64*NUM_INIT-1:0] init_data,
  output logic                   init_busy
);

  localparam int AW  = $clog2(DEPTH_BYTES);
  localparam int DWW = AW - 3;
  localparam int IW  = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  dmem_state_e    state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           rdy_q;
  logic           wr_q, wr_d;
  logic           err_q, err_d;
  logic [DWW-1:0] dw_q, dw_d;
  logic [63:0]    rdata_q, rdata_d;

  logic [63:0]    req_dw64;
  logic           req_ok;
  logic           accept;
  logic [63:0]    rd_word;

  logic           ld_start;
  logic           ld_last;
  logic           ld_sel;
  logic [IW-1:0]  ld_idx;
  logic [63:0]    ld_wdata;

  logic           we;
  logic [DWW-1:0] w_dw;
  logic [63:0]    w_data;

  dmem_init_loader #(
    .NUM_INIT (NUM_INIT),
    .IW       (IW)
  ) u_loader (
    .clk         (clk),
    .rst_n       (reset),
    .state_i     (state_q),
    .init_en_i   (init_en),
    .init_data_i (init_data),
    .start_o     (ld_start),
    .last_o      (ld_last),
    .wsel_o      (ld_sel),
    .idx_o       (ld_idx),
    .wdata_o     (ld_wdata)
  );

  always_comb begin
    req_dw64 = dw_index(req_addr);
    // high index bits are zero whenever addr_ok holds
    req_ok   = addr_ok(req_addr, 64'(DEPTH_BYTES)) &
               ~(|req_dw64[63:DWW]);
    // preload wins over a simultaneous request
    req_ready = rdy_q & (state_q == IDLE) & ~init_en;
    accept    = req_valid & req_ready;
    stall_req = (state_q != IDLE) |
                (req_valid & ~req_ready & rdy_q);
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = rdata_q;
    init_busy = (state_q == LOAD);

    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    dw_d    = dw_q;
    unique case (state_q)
      IDLE: begin
        if (init_en) begin
          state_d = LOAD;
        end else if (accept) begin
          wr_d  = req_write;
          err_d = ~req_ok;
          dw_d  = req_dw64[DWW-1:0];
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = ld_start ? LOAD : IDLE;
      end
      LOAD: begin
        if (ld_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // load data is sampled on the edge entering RESP
    for (int b = 0; b < DW_BYTES; b++) begin
      rd_word[8*b +: 8] = mem[{dw_d, 3'(b)}];
    end
    rdata_d = '0;
    if (state_d == RESP && !err_d && !wr_d) begin
      rdata_d = rd_word;
    end

    we     = ld_sel | (accept & req_write & req_ok);
    w_dw   = ld_sel ? DWW'(ld_idx) : req_dw64[DWW-1:0];
    w_data = ld_sel ? ld_wdata : req_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      dw_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      wr_q    <= wr_d;
      err_q   <= err_d;
      dw_q    <= dw_d;
      rdata_q <= rdata_d;
    end
  end

  // storage keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW_BYTES; b++) begin
        mem[{w_dw, 3'(b)}] <= w_data[8*b +: 8];
      end
    end
  end

endmodule
